// File: rtl/fadd_lane_arbiter_if.sv
// Bundle of request/response signals between the vector-ALU lanes and the
// shared FP32 adder arbiter.
//
// Signals:
//   req_valid  [NUM_LANES]     per-lane request valid (requester -> arbiter)
//   req_ready  [NUM_LANES]     per-lane accept, one-hot or zero (arbiter -> requester)
//   req_a/b    [32*NUM_LANES]  lane i operands at [32*i +: 32]
//   resp_valid                 result valid (arbiter -> consumer)
//   resp_ready                 consumer accepts result
//   resp_lane  [LANE_W]        lane that issued the result
//   resp_data  [32]            FP32 sum
//   resp_nan / resp_ovf        adder flags for this result
//   op_count   [32]            completed-response counter
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The sender keeps its payload stable
// while valid is high and ready is low; ready may depend combinationally on
// valid, valid never depends on ready.
//
// Modports: master = requester/consumer side, slave = arbiter side.
interface fadd_lane_arbiter_if #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
);
    logic [NUM_LANES-1:0]    req_valid;
    logic [NUM_LANES-1:0]    req_ready;
    logic [32*NUM_LANES-1:0] req_a;
    logic [32*NUM_LANES-1:0] req_b;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [LANE_W-1:0]       resp_lane;
    logic [31:0]             resp_data;
    logic                    resp_nan;
    logic                    resp_ovf;
    logic [31:0]             op_count;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_lane, resp_data, resp_nan, resp_ovf, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_lane, resp_data, resp_nan, resp_ovf, op_count
    );
endinterface

// File: rtl/fadd_lane_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 adder between NUM_LANES
// requesters. Operands are registered in stage 1, the adder sits between
// stage 1 and the output register (stage 2): 2-cycle latency, 1 op/cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fadd_lane_arbiter_if.slave (requests in, tagged responses out)
//
// float_adder_32: combinational IEEE-754 binary32 add, round-to-nearest-even,
// subnormals supported. nan_flag when the result is NaN (NaN input or
// inf - inf, canonical 0x7FC00000); overflow_flag when finite operands round
// past the largest finite value (result becomes signed infinity).
module float_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        nan_flag,
    output logic        overflow_flag
);
    logic        a_nan, b_nan, a_inf, b_inf, swap, rnd;
    logic [31:0] x, y;
    logic [23:0] mx, my;
    logic [7:0]  ex, ey, d;
    logic [4:0]  d_c;
    logic [58:0] y_wide;
    logic [26:0] y_al;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] m;

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        // x is the larger magnitude, so the result sign is x's sign.
        swap  = (b[30:0] > a[30:0]);
        x     = swap ? b : a;
        y     = swap ? a : b;
        ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx    = {x[30:23] != 8'd0, x[22:0]};
        my    = {y[30:23] != 8'd0, y[22:0]};
        d     = ex - ey;
        // Beyond 31 every bit of y lies below the guard position anyway.
        d_c    = (d > 8'd31) ? 5'd31 : d[4:0];
        y_wide = {my, 3'b000, 32'd0} >> d_c;
        y_al   = y_wide[58:32];
        y_al[0] = y_al[0] | (|y_wide[31:0]);  // sticky
        if (x[31] == y[31]) s = {1'b0, mx, 3'b000} + {1'b0, y_al};
        else                s = {1'b0, mx, 3'b000} - {1'b0, y_al};
        e = {2'b00, ex};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // Normalise left, stopping at the subnormal exponent.
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && e > 10'd1) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[26:3]} + {24'd0, rnd};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        sum           = 32'd0;
        nan_flag      = 1'b0;
        overflow_flag = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            sum      = 32'h7FC0_0000;
            nan_flag = 1'b1;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else if (e >= 10'd255) begin
            sum           = {x[31], 8'hFF, 23'd0};
            overflow_flag = 1'b1;
        end else if (m[23:0] == 24'd0) begin
            sum = {x[31] & y[31], 31'd0};
        end else begin
            // A hidden bit of 0 here means a subnormal result (e is 1).
            sum = {x[31], m[23] ? e[7:0] : 8'h00, m[22:0]};
        end
    end
endmodule

module fadd_lane_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    fadd_lane_arbiter_if.slave bus
);
    logic              s1_valid;
    logic [31:0]       s1_a, s1_b;
    logic [LANE_W-1:0] s1_lane, rr_ptr, gnt_idx, next_ptr;
    logic [LANE_W-1:0] cand [NUM_LANES];
    logic              gnt_found, stall, can_accept, accept;
    logic [31:0]       add_sum;
    logic              add_nan, add_ovf;

    assign stall      = bus.resp_valid & ~bus.resp_ready;
    // Stage 1 may refill whenever it is being drained or is already empty.
    assign can_accept = ~stall | ~s1_valid;
    assign accept     = gnt_found & can_accept & ~rst;
    assign next_ptr   = (gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0 : gnt_idx + LANE_W'(1);

    // Search order rr_ptr, rr_ptr+1, ... wrapping at NUM_LANES.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand[k] = LANE_W'((int'(rr_ptr) + k) % NUM_LANES);
            if (!gnt_found && bus.req_valid[cand[k]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[k];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt_idx] = 1'b1;
    end

    float_adder_32 u_add (
        .a             (s1_a),
        .b             (s1_b),
        .sum           (add_sum),
        .nan_flag      (add_nan),
        .overflow_flag (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_a           <= 32'd0;
            s1_b           <= 32'd0;
            s1_lane        <= '0;
            rr_ptr         <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= 32'd0;
            bus.resp_lane  <= '0;
            bus.resp_nan   <= 1'b0;
            bus.resp_ovf   <= 1'b0;
            bus.op_count   <= 32'd0;
        end else begin
            if (!stall) begin
                bus.resp_valid <= s1_valid;
                bus.resp_data  <= add_sum;
                bus.resp_lane  <= s1_lane;
                bus.resp_nan   <= add_nan;
                bus.resp_ovf   <= add_ovf;
            end
            if (can_accept) begin
                s1_valid <= gnt_found;
                if (gnt_found) begin
                    s1_a    <= bus.req_a[32*gnt_idx +: 32];
                    s1_b    <= bus.req_b[32*gnt_idx +: 32];
                    s1_lane <= gnt_idx;
                    rr_ptr  <= next_ptr;
                end
            end
            if (bus.resp_valid && bus.resp_ready) bus.op_count <= bus.op_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_fadd_lane_arbiter.sv
// Directed bench for fadd_lane_arbiter: a table of single-lane adds with
// hand-computed results, then hand-written multi-cycle sequences for
// round-robin order, backpressure and reset in flight.
module tb_fadd_lane_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fadd_lane_arbiter_if #(.NUM_LANES(4), .LANE_W(2)) bus ();

    fadd_lane_arbiter #(.NUM_LANES(4), .LANE_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  lane;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        nan;
        logic        ovf;
    } vec_t;

    vec_t        vecs [11];
    logic [35:0] exp_q [$];   // {lane, data, nan, ovf}
    logic [31:0] lane_b   [4];
    logic [31:0] lane_sum [4];
    logic [31:0] exp_ops;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] lane_item(input int l);
        return {2'(l), lane_sum[l], 2'b00};
    endfunction

    task automatic set_lane_ops();
        for (int l = 0; l < 4; l++) begin
            bus.req_a[32*l +: 32] = 32'h3F80_0000;
            bus.req_b[32*l +: 32] = lane_b[l];
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at the
    // falling edge. A non-zero exp_rdy pushes the expected response of the
    // op accepted at the coming edge.
    task automatic cyc(input logic r, input logic [3:0] v, input logic rr,
                       input logic [3:0] exp_rdy, input logic exp_rv, input logic [35:0] item);
        @(posedge clk);
        #1;
        rst            = r;
        bus.req_valid  = v;
        bus.resp_ready = rr;
        @(negedge clk);
        chk("req_ready", {32'd0, bus.req_ready}, {32'd0, exp_rdy});
        chk("op_count", {4'd0, bus.op_count}, {4'd0, exp_ops});
        chk("resp_valid", {35'd0, bus.resp_valid}, {35'd0, exp_rv});
        if (exp_rdy != 4'd0) exp_q.push_back(item);
        if (exp_rv && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got lane %0d data %h, expected no response",
                         bus.resp_lane, bus.resp_data);
            end else begin
                chk("resp", {bus.resp_lane, bus.resp_data, bus.resp_nan, bus.resp_ovf}, exp_q[0]);
                if (rr && !r) begin
                    void'(exp_q.pop_front());
                    exp_ops++;
                end
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, 1'b0};
        vecs[2]  = '{2'd1, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 1'b0, 1'b0};
        vecs[3]  = '{2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0};
        vecs[4]  = '{2'd2, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{2'd1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0, 1'b1};
        vecs[6]  = '{2'd0, 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 1'b0, 1'b0};
        vecs[7]  = '{2'd2, 32'h4000_0000, 32'hBF00_0000, 32'h3FC0_0000, 1'b0, 1'b0};
        vecs[8]  = '{2'd1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0};
        vecs[9]  = '{2'd3, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b0};
        vecs[10] = '{2'd3, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 1'b0, 1'b0};
        // Lane l adds 1.0 + (l+1): 2.0, 3.0, 4.0, 5.0.
        lane_b[0] = 32'h3F80_0000; lane_sum[0] = 32'h4000_0000;
        lane_b[1] = 32'h4000_0000; lane_sum[1] = 32'h4040_0000;
        lane_b[2] = 32'h4040_0000; lane_sum[2] = 32'h4080_0000;
        lane_b[3] = 32'h4080_0000; lane_sum[3] = 32'h40A0_0000;
        exp_ops = 32'd0;

        // Reset: ready must stay low with every lane requesting.
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {32'd0, bus.req_ready}, 36'd0);
        chk("rst_resp_valid", {35'd0, bus.resp_valid}, 36'd0);
        chk("rst_resp", {bus.resp_lane, bus.resp_data, bus.resp_nan, bus.resp_ovf}, 36'd0);
        chk("rst_op_count", {4'd0, bus.op_count}, 36'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 4'b0000;

        // Single-lane table: accept, one cycle in stage 1, result, consume.
        for (int i = 0; i < 11; i++) begin
            bus.req_a[32*int'(vecs[i].lane) +: 32] = vecs[i].a;
            bus.req_b[32*int'(vecs[i].lane) +: 32] = vecs[i].b;
            cyc(1'b0, 4'b0001 << vecs[i].lane, 1'b1, 4'b0001 << vecs[i].lane, 1'b0,
                {vecs[i].lane, vecs[i].data, vecs[i].nan, vecs[i].ovf});
            cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, '0);
            cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        end

        // All lanes requesting, last table op was lane 3 so rotation starts at 0.
        set_lane_ops();
        cyc(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, lane_item(0));
        cyc(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, lane_item(1));
        cyc(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, lane_item(2));
        cyc(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, lane_item(3));
        cyc(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, lane_item(0));
        cyc(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, lane_item(1));
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, '0);

        // Backpressure: output full and s1 empty allows one accept, then hold.
        cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, lane_item(2));
        cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, '0);
        cyc(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, lane_item(3));
        cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, lane_item(0));
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, '0);

        // Reset with both stages full: in-flight ops vanish, lane 0 first after.
        cyc(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, lane_item(1));
        cyc(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, lane_item(2));
        cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, '0);
        cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, '0);
        exp_q.delete();
        exp_ops = 32'd0;
        cyc(1'b0, 4'b1001, 1'b1, 4'b0001, 1'b0, lane_item(0));
        cyc(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, lane_item(3));
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, '0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, '0);
        chk("queue_drained", 36'(exp_q.size()), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
